// File: rtl/game_flow_ctrl.sv
// Game-flow controller for the air-fighter game: title, N levels, lives, pause,
// timed respawn and level-clear banner, driven by edge-detected keycodes.
module game_flow_ctrl #(
   parameter int         NUM_LEVELS  = 3,
   parameter int         NUM_LIVES   = 3,
   parameter logic [7:0] START_KEY   = 8'h28,
   parameter logic [7:0] PAUSE_KEY   = 8'h13,
   parameter int         RESPAWN_CYC = 60,
   parameter int         BANNER_CYC  = 120,
   parameter int         LEVEL_W     = $clog2(NUM_LEVELS + 1)
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic [7:0]         keycode,
   input  logic               level_done,
   input  logic               player_hit,
   output logic [LEVEL_W-1:0] level,
   output logic [3:0]         lives,
   output logic [2:0]         state_code,
   output logic               play_en,
   output logic               level_start,
   output logic               respawn
);

   localparam int TMAX = (RESPAWN_CYC > BANNER_CYC) ? RESPAWN_CYC : BANNER_CYC;
   localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PLAY     = 3'd1,
      S_PAUSED   = 3'd2,
      S_RESPAWN  = 3'd3,
      S_BANNER   = 3'd4,
      S_WIN      = 3'd5,
      S_GAMEOVER = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic [3:0]         lives_q, lives_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [7:0]         key_q;
   logic               play_en_q, play_en_d;
   logic               level_start_q, level_start_d;
   logic               respawn_q, respawn_d;
   logic               start_press, pause_press;

   // A press is the first cycle the keycode matches; holding it does not repeat.
   assign start_press = (keycode == START_KEY) && (key_q != START_KEY);
   assign pause_press = (keycode == PAUSE_KEY) && (key_q != PAUSE_KEY);

   always_comb begin
      state_d       = state_q;
      level_d       = level_q;
      lives_d       = lives_q;
      timer_d       = timer_q;
      level_start_d = 1'b0;
      respawn_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_press) begin
               state_d       = S_PLAY;
               level_d       = LEVEL_W'(1);
               lives_d       = 4'(NUM_LIVES);
               level_start_d = 1'b1;
            end
         end
         S_PLAY: begin
            if (player_hit) begin
               if (lives_q <= 4'd1) begin
                  state_d = S_GAMEOVER;
                  lives_d = 4'd0;
                  level_d = '0;
               end else begin
                  state_d = S_RESPAWN;
                  lives_d = lives_q - 4'd1;
                  timer_d = TW'(RESPAWN_CYC - 1);
               end
            end else if (level_done) begin
               if (level_q >= LEVEL_W'(NUM_LEVELS)) begin
                  state_d = S_WIN;
                  level_d = '0;
               end else begin
                  state_d = S_BANNER;
                  level_d = level_q + LEVEL_W'(1);
                  timer_d = TW'(BANNER_CYC - 1);
               end
            end else if (pause_press) begin
               state_d = S_PAUSED;
            end
         end
         S_PAUSED: begin
            if (pause_press) state_d = S_PLAY;
         end
         S_RESPAWN: begin
            if (timer_q == '0) begin
               state_d   = S_PLAY;
               respawn_d = 1'b1;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_BANNER: begin
            if (timer_q == '0) begin
               state_d       = S_PLAY;
               level_start_d = 1'b1;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_WIN, S_GAMEOVER: begin
            if (start_press) begin
               state_d = S_IDLE;
               lives_d = 4'd0;
               level_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            level_d = '0;
            lives_d = 4'd0;
            timer_d = '0;
         end
      endcase
      play_en_d = (state_d == S_PLAY);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q       <= S_IDLE;
         level_q       <= '0;
         lives_q       <= 4'd0;
         timer_q       <= '0;
         key_q         <= 8'h00;
         play_en_q     <= 1'b0;
         level_start_q <= 1'b0;
         respawn_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         level_q       <= level_d;
         lives_q       <= lives_d;
         timer_q       <= timer_d;
         key_q         <= keycode;
         play_en_q     <= play_en_d;
         level_start_q <= level_start_d;
         respawn_q     <= respawn_d;
      end
   end

   assign level       = level_q;
   assign lives       = lives_q;
   assign state_code  = state_q;
   assign play_en     = play_en_q;
   assign level_start = level_start_q;
   assign respawn     = respawn_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: start, banner, respawn, game over, win,
// hit-over-done priority, pause and asynchronous reset mid-banner.
module tb_game_flow_ctrl;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic [7:0] keycode;
   logic       level_done, player_hit;
   logic [1:0] level;
   logic [3:0] lives;
   logic [2:0] state_code;
   logic       play_en, level_start, respawn;

   int total = 0;
   int bad   = 0;

   localparam logic [7:0] K_START = 8'h28;
   localparam logic [7:0] K_PAUSE = 8'h13;

   game_flow_ctrl dut (
      .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode),
      .level_done(level_done), .player_hit(player_hit),
      .level(level), .lives(lives), .state_code(state_code),
      .play_en(play_en), .level_start(level_start), .respawn(respawn)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic press(input logic [7:0] k);
      keycode = k;
      step(1);
      keycode = 8'h00;
   endtask

   task automatic pulse_done();
      level_done = 1'b1;
      step(1);
      level_done = 1'b0;
   endtask

   task automatic pulse_hit();
      player_hit = 1'b1;
      step(1);
      player_hit = 1'b0;
   endtask

   // Counts cycles spent in state st (already entered), stepping until it leaves.
   task automatic dwell(input logic [2:0] st, output int cnt);
      cnt = 0;
      while (state_code == st && cnt < 1000) begin
         cnt++;
         step(1);
      end
      if (cnt >= 1000) chk("dwell_timeout", 32'(cnt), 32'd0);
   endtask

   initial begin
      int n, ls_cnt;
      Reset_n = 1'b0; keycode = 8'h00; level_done = 1'b0; player_hit = 1'b0;
      step(2);
      chk("rst_state", 32'(state_code), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_lives", 32'(lives), 32'd0);
      chk("rst_pulses", {29'd0, play_en, level_start, respawn}, 32'd0);
      Reset_n = 1'b1;
      step(1);

      // 1: held Enter gives one start
      keycode = K_START; ls_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (level_start) ls_cnt++;
      end
      keycode = 8'h00;
      chk("t1_state", 32'(state_code), 32'd1);
      chk("t1_level", 32'(level), 32'd1);
      chk("t1_lives", 32'(lives), 32'd3);
      chk("t1_ls_count", 32'(ls_cnt), 32'd1);
      chk("t1_play_en", 32'(play_en), 32'd1);
      step(1);

      // 2: level clear -> banner
      pulse_done();
      chk("t2_state", 32'(state_code), 32'd4);
      chk("t2_level", 32'(level), 32'd2);
      chk("t2_play_en", 32'(play_en), 32'd0);
      dwell(3'd4, n);
      chk("t2_banner_cyc", 32'(n), 32'd120);
      chk("t2_exit_state", 32'(state_code), 32'd1);
      chk("t2_level_start", 32'(level_start), 32'd1);
      step(1);
      chk("t2_ls_one_cycle", 32'(level_start), 32'd0);

      // 3: three hits -> game over
      pulse_hit();
      chk("t3_hit1_state", 32'(state_code), 32'd3);
      chk("t3_hit1_lives", 32'(lives), 32'd2);
      dwell(3'd3, n);
      chk("t3_resp1_cyc", 32'(n), 32'd60);
      chk("t3_respawn1", 32'(respawn), 32'd1);
      chk("t3_resp1_state", 32'(state_code), 32'd1);
      pulse_hit();
      chk("t3_hit2_lives", 32'(lives), 32'd1);
      dwell(3'd3, n);
      chk("t3_resp2_cyc", 32'(n), 32'd60);
      pulse_hit();
      chk("t3_gameover", 32'(state_code), 32'd6);
      chk("t3_go_level", 32'(level), 32'd0);
      chk("t3_go_lives", 32'(lives), 32'd0);
      // leaving game over with a held Enter must not restart
      keycode = K_START;
      step(1);
      chk("t3_to_idle", 32'(state_code), 32'd0);
      step(3);
      chk("t3_no_restart", 32'(state_code), 32'd0);
      keycode = 8'h00;
      step(1);
      press(K_START);
      chk("t3_restart", 32'(state_code), 32'd1);
      chk("t3_restart_lives", 32'(lives), 32'd3);

      // 4: get to level 3, then simultaneous hit and done
      pulse_done(); dwell(3'd4, n);
      pulse_done(); dwell(3'd4, n);
      chk("t4_level3", 32'(level), 32'd3);
      level_done = 1'b1; player_hit = 1'b1;
      step(1);
      level_done = 1'b0; player_hit = 1'b0;
      chk("t4_state", 32'(state_code), 32'd3);
      chk("t4_lives", 32'(lives), 32'd2);
      chk("t4_level", 32'(level), 32'd3);
      dwell(3'd3, n);
      chk("t4_back_play", 32'(state_code), 32'd1);

      // 5: pause ignores level_done
      press(K_PAUSE);
      chk("t5_paused", 32'(state_code), 32'd2);
      chk("t5_play_en", 32'(play_en), 32'd0);
      step(1);
      pulse_done();
      chk("t5_ignore_done", 32'(state_code), 32'd2);
      press(K_PAUSE);
      chk("t5_resume", 32'(state_code), 32'd1);
      chk("t5_level", 32'(level), 32'd3);

      // final level clear -> win -> idle
      step(1);
      pulse_done();
      chk("t5_win", 32'(state_code), 32'd5);
      chk("t5_win_level", 32'(level), 32'd0);
      chk("t5_win_lives", 32'(lives), 32'd2);
      press(K_START);
      chk("t5_win_idle", 32'(state_code), 32'd0);
      chk("t5_idle_lives", 32'(lives), 32'd0);
      step(1);

      // 6: async reset mid-banner at timer=50
      press(K_START);
      step(1);
      pulse_done();
      chk("t6_banner", 32'(state_code), 32'd4);
      step(69);
      chk("t6_still_banner", 32'(state_code), 32'd4);
      #2 Reset_n = 1'b0;
      #1;
      chk("t6_rst_state", 32'(state_code), 32'd0);
      chk("t6_rst_level", 32'(level), 32'd0);
      chk("t6_rst_lives", 32'(lives), 32'd0);
      step(1);
      Reset_n = 1'b1;
      ls_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         if (level_start || respawn) ls_cnt++;
      end
      chk("t6_no_pulse", 32'(ls_cnt), 32'd0);
      chk("t6_idle", 32'(state_code), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
